// File: rtl/cond_logic_if.sv
// Decoder/datapath-facing signal bundle for the conditional-execution stage.
// master drives the raw requests and ALU flags; slave returns the gated effects and flags.
interface cond_logic_if;
  logic [3:0] Cond;
  logic [3:0] ALUFlags;
  logic [1:0] FlagW;
  logic       PCS;
  logic       RegW;
  logic       MemW;
  logic       NoWrite;
  logic       PCSrc;
  logic       RegWrite;
  logic       MemWrite;
  logic       CondEx;
  logic [3:0] Flags;

  modport master (
    output Cond, ALUFlags, FlagW, PCS, RegW, MemW, NoWrite,
    input  PCSrc, RegWrite, MemWrite, CondEx, Flags
  );

  modport slave (
    input  Cond, ALUFlags, FlagW, PCS, RegW, MemW, NoWrite,
    output PCSrc, RegWrite, MemWrite, CondEx, Flags
  );
endinterface

// File: rtl/cond_logic.sv
// NZCV flag register, condition-field evaluation and side-effect gating
// for the single-cycle ARM-subset core.
module cond_logic (
  input  logic         clk,
  input  logic         reset_n,
  cond_logic_if.slave  bus
);

  localparam int unsigned FLAG_W = 4;

  logic [FLAG_W-1:0] flags_q;
  logic              n_f, z_f, c_f, v_f;
  logic              cond_ex;
  logic              nz_we, cv_we;

  assign {n_f, z_f, c_f, v_f} = flags_q;

  // Condition evaluated against registered flags only; an instruction never sees its own result.
  always_comb begin
    cond_ex = 1'b1;
    unique case (bus.Cond)
      4'b0000: cond_ex = z_f;
      4'b0001: cond_ex = ~z_f;
      4'b0010: cond_ex = c_f;
      4'b0011: cond_ex = ~c_f;
      4'b0100: cond_ex = n_f;
      4'b0101: cond_ex = ~n_f;
      4'b0110: cond_ex = v_f;
      4'b0111: cond_ex = ~v_f;
      4'b1000: cond_ex = c_f & ~z_f;
      4'b1001: cond_ex = ~c_f | z_f;
      4'b1010: cond_ex = (n_f == v_f);
      4'b1011: cond_ex = (n_f != v_f);
      4'b1100: cond_ex = ~z_f & (n_f == v_f);
      4'b1101: cond_ex = z_f | (n_f != v_f);
      4'b1110: cond_ex = 1'b1;
      4'b1111: cond_ex = 1'b1;
      default: cond_ex = 1'b1;
    endcase
  end

  assign nz_we = bus.FlagW[1] & cond_ex;
  assign cv_we = bus.FlagW[0] & cond_ex;

  // NZ and CV are separate fields so logic ops can update N,Z while C,V hold.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flags_q <= '0;
    end else begin
      if (nz_we) flags_q[3:2] <= bus.ALUFlags[3:2];
      if (cv_we) flags_q[1:0] <= bus.ALUFlags[1:0];
    end
  end

  assign bus.CondEx   = cond_ex;
  assign bus.PCSrc    = bus.PCS & cond_ex;
  assign bus.RegWrite = bus.RegW & cond_ex & ~bus.NoWrite;
  assign bus.MemWrite = bus.MemW & cond_ex;
  assign bus.Flags    = flags_q;

endmodule

// File: tb/tb_cond_logic.sv
// Directed bench for cond_logic: reset, flag setting, partial writes,
// suppressed side effects, CMP and a full condition-table sweep.
module tb_cond_logic;

  logic clk;
  logic reset_n;
  int   checks;
  int   errors;

  cond_logic_if bus ();

  cond_logic dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached (actual=timeout, required=finish)");
    $fatal(1);
  end

  // Reference condition model: grouped by code pair, odd code inverts, 111x always true.
  function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v, base;
    n = f[3]; z = f[2]; cf = f[1]; v = f[0];
    if (c[3:1] == 3'b111) return 1'b1;
    case (c[3:1])
      3'b000: base = z;
      3'b001: base = cf;
      3'b010: base = n;
      3'b011: base = v;
      3'b100: base = cf && !z;
      3'b101: base = !(n ^ v);
      3'b110: base = !z && !(n ^ v);
      default: base = 1'b1;
    endcase
    return c[0] ? !base : base;
  endfunction

  task automatic idle();
    bus.Cond     = 4'b1110;
    bus.ALUFlags = 4'b0000;
    bus.FlagW    = 2'b00;
    bus.PCS      = 1'b0;
    bus.RegW     = 1'b0;
    bus.MemW     = 1'b0;
    bus.NoWrite  = 1'b0;
  endtask

  // Load an arbitrary flag value through an always-executed S-instruction.
  task automatic set_flags(input logic [3:0] v);
    bus.Cond     = 4'b1110;
    bus.FlagW    = 2'b11;
    bus.ALUFlags = v;
    @(posedge clk); #1;
    idle();
  endtask

  task automatic test_reset();
    set_flags(4'b1111);
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (bus.Flags !== 4'b0000) begin
      errors++;
      $display("FAIL reset_async: Flags=%b expected=0000", bus.Flags);
    end
    bus.Cond = 4'b0000; #1;
    checks++;
    if (bus.CondEx !== 1'b0) begin
      errors++;
      $display("FAIL reset_eq: CondEx=%b expected=0", bus.CondEx);
    end
    bus.Cond = 4'b0001; #1;
    checks++;
    if (bus.CondEx !== 1'b1) begin
      errors++;
      $display("FAIL reset_ne: CondEx=%b expected=1", bus.CondEx);
    end
    // Pending update while reset is held must be lost.
    bus.Cond = 4'b1110; bus.FlagW = 2'b11; bus.ALUFlags = 4'b1111;
    @(posedge clk); #1;
    checks++;
    if (bus.Flags !== 4'b0000) begin
      errors++;
      $display("FAIL reset_hold: Flags=%b expected=0000", bus.Flags);
    end
    idle();
    #2 reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_subs_branch();
    set_flags(4'b0000);
    bus.Cond = 4'b1110; bus.FlagW = 2'b11; bus.ALUFlags = 4'b0110;
    @(posedge clk); #1;
    checks++;
    if (bus.Flags !== 4'b0110) begin
      errors++;
      $display("FAIL subs_flags: Flags=%b expected=0110", bus.Flags);
    end
    idle();
    bus.PCS = 1'b1; bus.Cond = 4'b0000; #1;
    checks++;
    if (bus.PCSrc !== 1'b1) begin
      errors++;
      $display("FAIL beq_taken: PCSrc=%b expected=1", bus.PCSrc);
    end
    bus.Cond = 4'b0001; #1;
    checks++;
    if (bus.PCSrc !== 1'b0) begin
      errors++;
      $display("FAIL bne_not_taken: PCSrc=%b expected=0", bus.PCSrc);
    end
    idle();
  endtask

  task automatic test_partial_write();
    set_flags(4'b0011);
    bus.Cond = 4'b1110; bus.FlagW = 2'b10; bus.ALUFlags = 4'b1000;
    @(posedge clk); #1;
    checks++;
    if (bus.Flags !== 4'b1011) begin
      errors++;
      $display("FAIL partial_nz: Flags=%b expected=1011", bus.Flags);
    end
    bus.FlagW = 2'b01; bus.ALUFlags = 4'b0100;
    @(posedge clk); #1;
    checks++;
    if (bus.Flags !== 4'b1000) begin
      errors++;
      $display("FAIL partial_cv: Flags=%b expected=1000", bus.Flags);
    end
    idle();
  endtask

  task automatic test_failed_cond();
    set_flags(4'b0000);
    bus.Cond = 4'b0000; bus.FlagW = 2'b11; bus.ALUFlags = 4'b1111;
    bus.RegW = 1'b1; bus.MemW = 1'b1; bus.PCS = 1'b1;
    #1;
    checks++;
    if ({bus.CondEx, bus.RegWrite, bus.MemWrite, bus.PCSrc} !== 4'b0000) begin
      errors++;
      $display("FAIL failed_gating: CondEx/RegWrite/MemWrite/PCSrc=%b expected=0000",
               {bus.CondEx, bus.RegWrite, bus.MemWrite, bus.PCSrc});
    end
    @(posedge clk); #1;
    checks++;
    if (bus.Flags !== 4'b0000) begin
      errors++;
      $display("FAIL failed_noflags: Flags=%b expected=0000", bus.Flags);
    end
    // Same requests with a passing condition take effect.
    bus.Cond = 4'b1110; bus.FlagW = 2'b00; #1;
    checks++;
    if ({bus.CondEx, bus.RegWrite, bus.MemWrite, bus.PCSrc} !== 4'b1111) begin
      errors++;
      $display("FAIL pass_gating: CondEx/RegWrite/MemWrite/PCSrc=%b expected=1111",
               {bus.CondEx, bus.RegWrite, bus.MemWrite, bus.PCSrc});
    end
    idle();
  endtask

  task automatic test_cmp();
    set_flags(4'b0000);
    bus.Cond = 4'b1110; bus.RegW = 1'b1; bus.NoWrite = 1'b1;
    bus.FlagW = 2'b11; bus.ALUFlags = 4'b1000;
    #1;
    checks++;
    if (bus.RegWrite !== 1'b0) begin
      errors++;
      $display("FAIL cmp_nowrite: RegWrite=%b expected=0", bus.RegWrite);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.Flags !== 4'b1000) begin
      errors++;
      $display("FAIL cmp_flags: Flags=%b expected=1000", bus.Flags);
    end
    idle();
    bus.Cond = 4'b1011; #1;
    checks++;
    if (bus.CondEx !== 1'b1) begin
      errors++;
      $display("FAIL cmp_lt: CondEx=%b expected=1", bus.CondEx);
    end
    bus.Cond = 4'b1100; #1;
    checks++;
    if (bus.CondEx !== 1'b0) begin
      errors++;
      $display("FAIL cmp_gt: CondEx=%b expected=0", bus.CondEx);
    end
    idle();
  endtask

  task automatic test_back_to_back();
    // Evaluation sees old Z=1 while the same instruction clears it.
    set_flags(4'b0100);
    bus.Cond = 4'b0000; bus.FlagW = 2'b11; bus.ALUFlags = 4'b0000; #1;
    checks++;
    if (bus.CondEx !== 1'b1) begin
      errors++;
      $display("FAIL b2b_old_flags: CondEx=%b expected=1", bus.CondEx);
    end
    @(posedge clk); #1;
    idle();
    bus.Cond = 4'b0000; #1;
    checks++;
    if (bus.CondEx !== 1'b0) begin
      errors++;
      $display("FAIL b2b_new_flags: CondEx=%b expected=0", bus.CondEx);
    end
    idle();
  endtask

  task automatic test_sweep();
    for (int f = 0; f < 16; f++) begin
      set_flags(4'(f));
      checks++;
      if (bus.Flags !== 4'(f)) begin
        errors++;
        $display("FAIL sweep_load: Flags=%b expected=%b", bus.Flags, 4'(f));
      end
      for (int c = 0; c < 16; c++) begin
        bus.Cond = 4'(c);
        #1;
        checks++;
        if (bus.CondEx !== ref_cond(4'(c), 4'(f))) begin
          errors++;
          $display("FAIL sweep_cond: Flags=%b Cond=%b CondEx=%b expected=%b",
                   4'(f), 4'(c), bus.CondEx, ref_cond(4'(c), 4'(f)));
        end
      end
      idle();
    end
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    reset_n = 1'b0;
    idle();
    #2;
    checks++;
    if (bus.Flags !== 4'b0000) begin
      errors++;
      $display("FAIL initial_reset: Flags=%b expected=0000", bus.Flags);
    end
    #10 reset_n = 1'b1;
    @(posedge clk); #1;

    test_reset();
    test_subs_branch();
    test_partial_write();
    test_failed_cond();
    test_cmp();
    test_back_to_back();
    test_sweep();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
